// File: rtl/ps2_codes_pkg.sv
// Shared PS/2 set-2 byte constants and the scan parser state encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ps2_codes_pkg;

  localparam logic [7:0] PS2_EXT   = 8'hE0;  // extended-key prefix
  localparam logic [7:0] PS2_BRK   = 8'hF0;  // break (key up) prefix
  localparam logic [7:0] PS2_BAT   = 8'hAA;  // keyboard self-test passed
  localparam logic [7:0] PS2_PAUSE = 8'hE1;  // pause key sequence start
  localparam logic [7:0] PS2_ERR0  = 8'h00;  // buffer overrun / error
  localparam logic [7:0] PS2_ERR1  = 8'hFF;  // buffer overrun / error

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,  // E0 seen
    ST_BRK     = 2'd2,  // F0 seen
    ST_EXT_BRK = 2'd3   // E0,F0 seen
  } ps2_state_e;

  // Bytes that abort any pending prefix and never produce a key event.
  function automatic logic is_drop_code(input logic [7:0] b);
    return (b == PS2_PAUSE) || (b == PS2_ERR0) || (b == PS2_ERR1);
  endfunction

endpackage

// File: rtl/ps2_key_tracker_if.sv
// Byte stream from PS2_Controller into the key tracker.
// Latency: n/a (wires only).
// Backpressure: none; received_data_en is a one-cycle strobe that cannot be stalled.
//   received_data     8-bit scancode byte
//   received_data_en  strobe, received_data valid this cycle
interface ps2_key_tracker_if;
  logic [7:0] received_data;
  logic       received_data_en;

  modport master (output received_data, output received_data_en);
  modport slave  (input  received_data, input  received_data_en);
endinterface

// File: rtl/ps2_scan_parser.sv
// Prefix parser: turns E0/F0-prefixed scancode bytes into make/break/BAT events.
// Latency: events are combinational in the strobe cycle; state advances on that edge.
// Backpressure: none; every strobe is consumed, back-to-back strobes included.
//   clk, rst            clock, async active-high reset
//   data, data_en       incoming byte and its strobe
//   evt_valid           an event is present this cycle
//   evt_make/evt_ext    make (1) or break (0); E0 prefix seen
//   evt_code            scancode of the event
//   evt_bat             keyboard BAT-ok byte (AA) seen in IDLE
module ps2_scan_parser
  import ps2_codes_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       data_en,
  output logic       evt_valid,
  output logic       evt_make,
  output logic       evt_ext,
  output logic [7:0] evt_code,
  output logic       evt_bat
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  ps2_state_e    state;
  ps2_state_e    state_nxt;
  logic [CW-1:0] idle_cnt;

  // Events are decoded from the current state and the byte in the strobe
  // cycle, so the key state registers in the top see them on the same edge
  // that advances the parser: one cycle from strobe to key outputs.
  always_comb begin
    evt_valid = 1'b0;
    evt_make  = 1'b0;
    evt_ext   = 1'b0;
    evt_bat   = 1'b0;
    evt_code  = data;
    state_nxt = state;
    if (data_en) begin
      case (state)
        ST_IDLE, ST_EXT: begin
          if (data == PS2_BRK) begin
            state_nxt = (state == ST_EXT) ? ST_EXT_BRK : ST_BRK;
          end else if (data == PS2_EXT) begin
            state_nxt = ST_EXT;
          end else if (is_drop_code(data)) begin
            state_nxt = ST_IDLE;
          end else if (state == ST_IDLE && data == PS2_BAT) begin
            evt_valid = 1'b1;
            evt_bat   = 1'b1;
          end else begin
            evt_valid = 1'b1;
            evt_make  = 1'b1;
            evt_ext   = (state == ST_EXT);
            state_nxt = ST_IDLE;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          if (!(data == PS2_EXT || data == PS2_BRK || is_drop_code(data))) begin
            evt_valid = 1'b1;
            evt_ext   = (state == ST_EXT_BRK);
          end
        end
      endcase
    end
  end

  // A prefix left dangling (lost byte, unplugged keyboard) is dropped after
  // TIMEOUT_CYCLES strobe-free cycles so the next byte starts clean.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      idle_cnt <= '0;
    end else if (data_en) begin
      state    <= state_nxt;
      idle_cnt <= '0;
    end else if (state == ST_IDLE) begin
      idle_cnt <= '0;
    end else if (idle_cnt >= CNT_LAST) begin
      state    <= ST_IDLE;
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ps2_key_tracker.sv
// Tracks make/break state of a configurable set of PS/2 set-2 keys.
// Latency: key_held/key_press/key_release/last_key 1 cycle after the strobe; any_held combinational.
// Backpressure: none; accepts a byte on every cycle.
//   CLOCK_50, reset     clock, async active-high reset
//   rx                  byte stream from PS2_Controller (slave modport)
//   key_held            per-key held level (HOLD_MODE=0: one-hot of last make)
//   key_press           one-cycle pulse on a make of a key not already held
//   key_release         one-cycle pulse on a break of a held key
//   last_key            index of the most recent make
//   any_held            OR of key_held
module ps2_key_tracker
  import ps2_codes_pkg::*;
#(
  parameter int                  NUM_KEYS       = 4,
  parameter logic [8*NUM_KEYS-1:0] KEY_CODES    = {8'h72, 8'h75, 8'h74, 8'h6B},
  parameter logic [NUM_KEYS-1:0] KEY_EXT        = 4'b1111,
  parameter bit                  HOLD_MODE      = 1'b1,
  parameter int                  TIMEOUT_CYCLES = 50000,
  localparam int                 IW             = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  ps2_key_tracker_if.slave    rx,
  output logic [NUM_KEYS-1:0] key_held,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [IW-1:0]       last_key,
  output logic                any_held
);

  logic       evt_valid;
  logic       evt_make;
  logic       evt_ext;
  logic [7:0] evt_code;
  logic       evt_bat;

  ps2_scan_parser #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_parser (
    .clk       (CLOCK_50),
    .rst       (reset),
    .data      (rx.received_data),
    .data_en   (rx.received_data_en),
    .evt_valid (evt_valid),
    .evt_make  (evt_make),
    .evt_ext   (evt_ext),
    .evt_code  (evt_code),
    .evt_bat   (evt_bat)
  );

  logic [NUM_KEYS-1:0] make_hit;
  logic [NUM_KEYS-1:0] brk_hit;
  logic [NUM_KEYS-1:0] held_nxt;
  logic [NUM_KEYS-1:0] press_nxt;
  logic [NUM_KEYS-1:0] rel_nxt;
  logic [IW-1:0]       first_idx;
  logic                bat;
  logic                any_make;

  assign bat      = evt_valid & evt_bat;
  assign any_make = |make_hit;

  // Duplicate codes are legal, so every matching key is updated.
  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    logic hit;
    assign hit         = evt_valid && !evt_bat &&
                         (evt_code == KEY_CODES[8*i +: 8]) && (evt_ext == KEY_EXT[i]);
    assign make_hit[i] = hit & evt_make;
    assign brk_hit[i]  = hit & ~evt_make;
    if (HOLD_MODE) begin : g_level
      assign held_nxt[i] = bat ? 1'b0 : ((key_held[i] | make_hit[i]) & ~brk_hit[i]);
    end else begin : g_onehot
      assign held_nxt[i] = bat ? 1'b0 :
                           any_make ? make_hit[i] : (key_held[i] & ~brk_hit[i]);
    end
    // Typematic repeats arrive as further makes of a held key: no pulse.
    assign press_nxt[i] = make_hit[i] & ~key_held[i];
    assign rel_nxt[i]   = brk_hit[i] & key_held[i];
  end

  // Lowest matching index wins when several keys share a code.
  always_comb begin
    first_idx = '0;
    for (int k = NUM_KEYS - 1; k >= 0; k--) begin
      if (make_hit[k]) first_idx = IW'(k);
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      key_held    <= '0;
      key_press   <= '0;
      key_release <= '0;
      last_key    <= '0;
    end else begin
      key_held    <= held_nxt;
      key_press   <= press_nxt;
      key_release <= rel_nxt;
      if (any_make) last_key <= first_idx;
    end
  end

  assign any_held = |key_held;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Self-checking bench: directed scenarios plus random byte traffic against a reference model.
// Latency: model expects key outputs one cycle after each strobe.
// Backpressure: none; stimulus strobes freely, including back-to-back.
module tb_ps2_key_tracker;

  localparam int T = 200;  // shortened prefix timeout for simulation

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ps2_key_tracker_if bus ();

  logic [3:0] held1, press1, rel1, held0, press0, rel0;
  logic [1:0] lk1, lk0;
  logic       any1, any0;

  ps2_key_tracker #(.TIMEOUT_CYCLES(T)) dut1 (
    .CLOCK_50(clk), .reset(rst), .rx(bus),
    .key_held(held1), .key_press(press1), .key_release(rel1),
    .last_key(lk1), .any_held(any1)
  );

  ps2_key_tracker #(.HOLD_MODE(1'b0), .TIMEOUT_CYCLES(T)) dut0 (
    .CLOCK_50(clk), .reset(rst), .rx(bus),
    .key_held(held0), .key_press(press0), .key_release(rel0),
    .last_key(lk0), .any_held(any0)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: prefix flags, idle counter, per-key state for both modes.
  logic [7:0] codes [4];
  bit   [3:0] kext = 4'b1111;
  bit m_ext, m_brk;
  int m_idle;
  bit [3:0] mh1, mp1, mr1, mh0, mp0, mr0;
  bit [1:0] ml;

  task automatic model_reset();
    m_ext = 0; m_brk = 0; m_idle = 0;
    mh1 = 0; mp1 = 0; mr1 = 0; mh0 = 0; mp0 = 0; mr0 = 0; ml = 0;
  endtask

  task automatic apply_make(input logic [7:0] b, input bit e);
    bit [3:0] hit;
    int first;
    hit = 0; first = -1;
    for (int i = 0; i < 4; i++)
      if (codes[i] == b && kext[i] == e) begin
        hit[i] = 1;
        if (first < 0) first = i;
      end
    if (first >= 0) begin
      mp1 = hit & ~mh1; mh1 = mh1 | hit;
      mp0 = hit & ~mh0; mh0 = hit;
      ml  = 2'(first);
    end
  endtask

  task automatic apply_break(input logic [7:0] b, input bit e);
    for (int i = 0; i < 4; i++)
      if (codes[i] == b && kext[i] == e) begin
        if (mh1[i]) begin mh1[i] = 0; mr1[i] = 1; end
        if (mh0[i]) begin mh0[i] = 0; mr0[i] = 1; end
      end
  endtask

  task automatic model_step(input bit en, input logic [7:0] b);
    bit drop;
    mp1 = 0; mr1 = 0; mp0 = 0; mr0 = 0;
    drop = (b == 8'hE1) || (b == 8'h00) || (b == 8'hFF);
    if (en) begin
      m_idle = 0;
      if (!m_brk) begin
        if (b == 8'hF0) m_brk = 1;
        else if (b == 8'hE0) m_ext = 1;
        else if (drop) m_ext = 0;
        else if (!m_ext && b == 8'hAA) begin mh1 = 0; mh0 = 0; end
        else begin apply_make(b, m_ext); m_ext = 0; end
      end else begin
        if (!(b == 8'hE0 || b == 8'hF0 || drop)) apply_break(b, m_ext);
        m_ext = 0; m_brk = 0;
      end
    end else if (m_ext || m_brk) begin
      m_idle++;
      if (m_idle >= T) begin m_ext = 0; m_brk = 0; m_idle = 0; end
    end
  endtask

  // Drive one cycle (called #1 after a rising edge), advance model, sample #1 after edge.
  task automatic step(input bit en, input logic [7:0] b);
    bus.received_data_en = en;
    bus.received_data    = en ? b : 8'($urandom);
    model_step(en, b);
    @(posedge clk);
    #1;
    bus.received_data_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 8'h00);
  endtask

  task automatic send_ext(input logic [7:0] b);
    step(1'b1, 8'hE0);
    step(1'b1, b);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    bus.received_data_en = 1'b1;
    bus.received_data    = 8'hE0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({held1, press1, rel1, lk1, any1, held0, press0, rel0, lk0, any0} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got h1=%b p1=%b r1=%b lk1=%0d a1=%b h0=%b, want all zero",
               held1, press1, rel1, lk1, any1, held0);
    end
    bus.received_data_en = 1'b0;
    rst = 1'b0;
    step(1'b1, 8'h6B);  // would be a make of left had E0 survived reset
    checks++;
    if (held1 !== 4'b0000) begin
      errors++; $display("FAIL reset_no_prefix: got %b want 0000", held1);
    end
  endtask

  task automatic test_ext_make_break();
    send_ext(8'h6B);
    checks++;
    if (held1 !== 4'b0001 || press1 !== 4'b0001 || lk1 !== 2'd0) begin
      errors++;
      $display("FAIL make_left: got h=%b p=%b lk=%0d want 0001 0001 0", held1, press1, lk1);
    end
    idle(1);
    checks++;
    if (press1 !== 4'b0000 || held1 !== 4'b0001) begin
      errors++; $display("FAIL press_one_cycle: got p=%b h=%b want 0000 0001", press1, held1);
    end
    step(1'b1, 8'hE0); step(1'b1, 8'hF0); step(1'b1, 8'h6B);
    checks++;
    if (held1 !== 4'b0000 || rel1 !== 4'b0001) begin
      errors++; $display("FAIL break_left: got h=%b r=%b want 0000 0001", held1, rel1);
    end
    idle(1);
    checks++;
    if (rel1 !== 4'b0000) begin
      errors++; $display("FAIL release_one_cycle: got %b want 0000", rel1);
    end
  endtask

  task automatic test_repeat();
    int pulses;
    pulses = 0;
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 8'hE0);
      step(1'b1, 8'h75);
      pulses += int'(press1[2]);
    end
    checks++;
    if (pulses != 1 || held1 !== 4'b0100) begin
      errors++; $display("FAIL repeat_suppress: got pulses=%0d h=%b want 1 0100", pulses, held1);
    end
  endtask

  task automatic test_plain_and_onehot();
    step(1'b1, 8'h6B);
    checks++;
    if (held1 !== 4'b0100 || press1 !== 4'b0000 || lk1 !== 2'd2) begin
      errors++; $display("FAIL plain_ignored: got h=%b p=%b lk=%0d want 0100 0000 2", held1, press1, lk1);
    end
    send_ext(8'h6B);
    checks++;
    if (held0 !== 4'b0001) begin
      errors++; $display("FAIL onehot_left: got %b want 0001", held0);
    end
    send_ext(8'h74);
    checks++;
    if (held0 !== 4'b0010 || lk0 !== 2'd1 || held1 !== 4'b0111) begin
      errors++; $display("FAIL onehot_right: got h0=%b lk0=%0d h1=%b want 0010 1 0111", held0, lk0, held1);
    end
  endtask

  task automatic test_bat();
    step(1'b1, 8'hAA);
    send_ext(8'h75);
    send_ext(8'h72);
    checks++;
    if (held1 !== 4'b1100 || any1 !== 1'b1 || lk1 !== 2'd3) begin
      errors++; $display("FAIL up_down_held: got h=%b any=%b lk=%0d want 1100 1 3", held1, any1, lk1);
    end
    step(1'b1, 8'hAA);
    checks++;
    if (held1 !== 4'b0000 || rel1 !== 4'b0000 || any1 !== 1'b0 || held0 !== 4'b0000) begin
      errors++; $display("FAIL bat_clear: got h=%b r=%b any=%b h0=%b want 0000 0000 0 0000",
                         held1, rel1, any1, held0);
    end
  endtask

  task automatic test_timeout();
    step(1'b1, 8'hE0);
    idle(T);
    step(1'b1, 8'h72);
    checks++;
    if (held1 !== 4'b0000) begin
      errors++; $display("FAIL timeout_drop: got %b want 0000", held1);
    end
    step(1'b1, 8'hE0);
    idle(T - 1);
    step(1'b1, 8'h72);
    checks++;
    if (held1 !== 4'b1000 || held0 !== 4'b1000) begin
      errors++; $display("FAIL timeout_edge: got h1=%b h0=%b want 1000 1000", held1, held0);
    end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 8'hE0); step(1'b1, 8'hF0);
    rst = 1'b1;
    model_reset();
    #2;
    checks++;
    if ({held1, press1, rel1, lk1, any1, held0, lk0, any0} !== '0) begin
      errors++; $display("FAIL reset_async: got h1=%b lk1=%0d any1=%b want all zero", held1, lk1, any1);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    step(1'b1, 8'h6B);
    checks++;
    if (held1 !== 4'b0000 || rel1 !== 4'b0000 || press1 !== 4'b0000) begin
      errors++; $display("FAIL reset_mid_brk: got h=%b p=%b r=%b want zero", held1, press1, rel1);
    end
    step(1'b1, 8'hE0);
    rst = 1'b1; model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    step(1'b1, 8'h6B);
    checks++;
    if (held1 !== 4'b0000) begin
      errors++; $display("FAIL reset_mid_ext: got %b want 0000", held1);
    end
  endtask

  task automatic test_random();
    logic [7:0] pool [12];
    logic [7:0] b;
    bit en;
    pool = '{8'hE0, 8'hF0, 8'hE0, 8'hF0, 8'h6B, 8'h74, 8'h75, 8'h72, 8'hAA, 8'hE1, 8'h00, 8'hFF};
    for (int n = 0; n < 600; n++) begin
      en = ($urandom_range(0, 2) != 0);
      b  = ($urandom_range(0, 9) == 0) ? 8'($urandom) : pool[$urandom_range(0, 11)];
      step(en, b);
      checks++;
      if ({held1, press1, rel1, lk1, any1, held0, press0, rel0, lk0, any0} !==
          {mh1, mp1, mr1, ml, |mh1, mh0, mp0, mr0, ml, |mh0}) begin
        errors++;
        $display("FAIL random_%0d: got h1=%b p1=%b r1=%b lk=%0d h0=%b p0=%b r0=%b lk0=%0d want h1=%b p1=%b r1=%b lk=%0d h0=%b p0=%b r0=%b",
                 n, held1, press1, rel1, lk1, held0, press0, rel0, lk0,
                 mh1, mp1, mr1, ml, mh0, mp0, mr0);
      end
    end
  endtask

  initial begin
    codes = '{8'h6B, 8'h74, 8'h75, 8'h72};
    bus.received_data_en = 1'b0;
    bus.received_data    = 8'h00;
    #1;
    test_reset();
    test_ext_make_break();
    test_repeat();
    test_plain_and_onehot();
    test_bat();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
